// File: rtl/module_display_mux_if.sv
// Display-mux bus: packed-BCD operands, load/blanking controls and the
// registered segment/anode pins, grouped so upstream and display sides share one bundle.
interface module_display_mux_if #(
    parameter int WIDTH_BCD = 8
);
    logic [WIDTH_BCD-1:0] bcd_1;
    logic [WIDTH_BCD-1:0] bcd_2;
    logic                 load;
    logic                 blank_lz;
    logic [6:0]           seg;
    logic [3:0]           an;

    // Upstream side: supplies BCD data and controls, observes the pins.
    modport master (
        output bcd_1, bcd_2, load, blank_lz,
        input  seg, an
    );

    // Display driver side.
    modport slave (
        input  bcd_1, bcd_2, load, blank_lz,
        output seg, an
    );
endinterface

// File: rtl/module_display_mux.sv
// Time-multiplexed 4-digit common-anode 7-segment driver.
// Shows {bcd_2 tens, bcd_2 units, bcd_1 tens, bcd_1 units} from a shadow copy
// of the inputs, scanning one digit per REFRESH_DIV clocks, with optional
// leading-zero blanking of the tens digits and a dash for non-BCD nibbles.
module module_display_mux #(
    parameter int WIDTH_BCD      = 8,
    parameter int REFRESH_DIV    = 27000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    module_display_mux_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

    // One state per digit slot, in scan order.
    typedef enum logic [1:0] {
        S0 = 2'd0,  // bcd_1 units
        S1 = 2'd1,  // bcd_1 tens
        S2 = 2'd2,  // bcd_2 units
        S3 = 2'd3   // bcd_2 tens
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH_BCD-1:0] shadow_1;
    logic [WIDTH_BCD-1:0] shadow_2;
    logic [CNT_W-1:0]     count;
    logic                 tick;
    logic [3:0]           nibble;
    logic                 blank;
    logic [6:0]           seg_hi;
    logic [3:0]           an_hi;
    logic [6:0]           seg_d;
    logic [3:0]           an_d;
    logic [6:0]           seg_q;
    logic [3:0]           an_q;

    // Active-high gfedcba pattern; anything outside 0..9 shows a dash.
    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        case (d)
            4'd0:    decode_digit = 7'h3F;
            4'd1:    decode_digit = 7'h06;
            4'd2:    decode_digit = 7'h5B;
            4'd3:    decode_digit = 7'h4F;
            4'd4:    decode_digit = 7'h66;
            4'd5:    decode_digit = 7'h6D;
            4'd6:    decode_digit = 7'h7D;
            4'd7:    decode_digit = 7'h07;
            4'd8:    decode_digit = 7'h7F;
            4'd9:    decode_digit = 7'h6F;
            default: decode_digit = 7'h40;
        endcase
    endfunction

    // Shadow latch: the display only ever reads these, never the live inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            // NOTE: these are a pair of plain registers, not a memory, so clearing them in reset is cheap and gives a defined "00 00" display.
            shadow_1 <= '0;
            shadow_2 <= '0;
        end else if (bus.load) begin
            shadow_1 <= bus.bcd_1;
            shadow_2 <= bus.bcd_2;
        end
    end

    // Refresh prescaler: tick marks the last cycle of each digit slot.
    assign tick = (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Scan FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Scan FSM next state: step to the following digit on each tick.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (tick) begin
            case (state)
                S0:      state_next = S1;
                S1:      state_next = S2;
                S2:      state_next = S3;
                default: state_next = S0;
            endcase
        end
    end

    // Scan FSM outputs: pick the slot's nibble and anode, decode, apply blanking and polarity.
    always_comb begin
        nibble = shadow_1[3:0];
        an_hi  = 4'b0001;
        case (state)
            S0: begin nibble = shadow_1[3:0]; an_hi = 4'b0001; end
            S1: begin nibble = shadow_1[7:4]; an_hi = 4'b0010; end
            S2: begin nibble = shadow_2[3:0]; an_hi = 4'b0100; end
            S3: begin nibble = shadow_2[7:4]; an_hi = 4'b1000; end
            default: ;
        endcase
        blank  = bus.blank_lz && ((state == S1) || (state == S3)) && (nibble == 4'd0);
        seg_hi = decode_digit(nibble);
        if (blank) begin
            seg_hi = 7'h00;
            an_hi  = 4'b0000;
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        an_d  = AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
    end

    // Output registers: pins change one cycle after the state/shadow they reflect.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_module_display_mux.sv
// Self-checking bench for module_display_mux (REFRESH_DIV=4, active-low pins).
// The reference model counts clock edges since the last reset and derives the
// visible slot arithmetically, alongside a copy of the loaded BCD bytes.
module tb_module_display_mux;

    localparam int DIV = 4;

    logic clk;
    logic rst;

    module_display_mux_if #(.WIDTH_BCD(8)) bus ();

    module_display_mux #(
        .WIDTH_BCD     (8),
        .REFRESH_DIV   (DIV),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model state: edges seen since reset and the loaded {bcd_2, bcd_1}.
    int          n        = 0;
    logic [15:0] m_shadow = '0;

    localparam logic [6:0] DIGITS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Expected active-low pins for a digit slot (0 = bcd_1 units .. 3 = bcd_2 tens).
    function automatic void model_out(input int slot, input logic [15:0] sh, input logic blank_lz,
                                      output logic [6:0] es, output logic [3:0] ea);
        int d;
        d = int'((sh >> (4 * slot)) & 16'hF);
        if (blank_lz && (slot % 2 == 1) && d == 0) begin
            es = 7'h7F;
            ea = 4'hF;
        end else begin
            es = ~((d <= 9) ? DIGITS[d] : 7'h40);
            ea = ~(4'b0001 << slot);
        end
    endfunction

    task automatic compare(input string tag, input logic [6:0] es, input logic [3:0] ea);
        compared++;
        assert (bus.seg === es && bus.an === ea)
        else begin
            mismatched++;
            $error("FAIL %s (edge %0d): seg/an = %h/%b, expected %h/%b",
                   tag, n, bus.seg, bus.an, es, ea);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then check pins.
    task automatic step(input string tag);
        logic [6:0] es;
        logic [3:0] ea;
        @(posedge clk);
        if (rst) begin
            es       = 7'h7F;
            ea       = 4'hF;
            n        = 0;
            m_shadow = '0;
        end else begin
            model_out((n / DIV) % 4, m_shadow, bus.blank_lz, es, ea);
            if (bus.load) m_shadow = {bus.bcd_2, bus.bcd_1};
            n++;
        end
        #1;
        compare(tag, es, ea);
    endtask

    task automatic run_until(input int k);
        while (n < k) step("scan");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.bcd_1    = '0;
        bus.bcd_2    = '0;

        // Reset held for three edges.
        repeat (3) step("reset");
        compare("reset_state", 7'h7F, 4'b1111);

        // First slot after reset shows zero; load 07/15 on that same edge.
        rst       = 1'b0;
        bus.bcd_1 = 8'h07;
        bus.bcd_2 = 8'h15;
        bus.load  = 1'b1;
        step("first_slot");
        compare("s0_zero", 7'h40, 4'b1110);
        bus.load = 1'b0;

        // Full scan, each slot 4 cycles, then wrap.
        run_until(2);  compare("scan_s0",   7'h78, 4'b1110);
        run_until(5);  compare("scan_s1",   7'h40, 4'b1101);
        run_until(9);  compare("scan_s2",   7'h12, 4'b1011);
        run_until(13); compare("scan_s3",   7'h79, 4'b0111);
        run_until(17); compare("scan_wrap", 7'h78, 4'b1110);

        // Leading-zero blanking: S1 tens is 0 and blanks, S3 tens is 1 and shows.
        run_until(20);
        bus.blank_lz = 1'b1;
        run_until(22); compare("blank_s1", 7'h7F, 4'b1111);
        run_until(30); compare("blank_s3", 7'h79, 4'b0111);

        // Non-BCD units nibble shows a dash.
        run_until(32);
        bus.bcd_1 = 8'h0C;
        bus.load  = 1'b1;
        step("load_invalid");
        bus.load = 1'b0;
        run_until(34); compare("invalid_dash", 7'h3F, 4'b1110);

        // Input change without load is ignored.
        bus.bcd_1 = 8'h09;
        run_until(36); compare("latch_hold", 7'h3F, 4'b1110);
        bus.blank_lz = 1'b0;

        // Load on a tick edge: the next slot shows the new value one cycle later.
        run_until(47);
        bus.load = 1'b1;
        step("load_on_tick");
        bus.load = 1'b0;
        step("after_tick");
        compare("latch_tick", 7'h10, 4'b1110);

        // Reset for one edge while in S2, then a full-length S0 slot of zeros.
        run_until(58);
        rst = 1'b1;
        step("midscan_reset");
        compare("midscan_off", 7'h7F, 4'b1111);
        rst = 1'b0;
        for (int i = 0; i < DIV; i++) begin
            step("restart");
            compare("restart_s0", 7'h40, 4'b1110);
        end
        step("restart_next");
        compare("restart_s1", 7'h40, 4'b1101);

        // Randomised traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            bus.load     = ($urandom_range(0, 5) == 0);
            bus.blank_lz = 1'($urandom_range(0, 1));
            bus.bcd_1    = 8'($urandom);
            bus.bcd_2    = 8'($urandom);
            if ($urandom_range(0, 1) == 1) bus.bcd_1[7:4] = 4'h0;
            if ($urandom_range(0, 1) == 1) bus.bcd_2[7:4] = 4'h0;
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
